// File: rtl/sd_pkg.sv
// sd_pkg: shared types and constants for the SD data-line receive/transmit paths.
package sd_pkg;
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_START = 3'd1,
    RCV_DATA   = 3'd2,
    RCV_CRC    = 3'd3,
    END_BIT    = 3'd4
  } state_t;
  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic START_BIT = 1'b0;
  localparam logic END_BIT_VAL = 1'b1;
endpackage

// File: rtl/sd_crc16.sv
// sd_crc16: serial MSB-first CRC16 (init 0, no final XOR), shared by read and write paths.
module sd_crc16
  import sd_pkg::*;
#(
  parameter logic [15:0] POLY = CRC16_POLY
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);
  logic fb;
  assign fb = crc[15] ^ din;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) crc <= '0;
    else if (clr) crc <= '0;
    else if (en) crc <= {crc[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
  end
endmodule

// File: rtl/sd_dat_block_rx.sv
// sd_dat_block_rx: 1-bit DAT0 single-block read engine feeding the USB read FIFO,
// with CRC16/end-bit check and start-bit timeout.
module sd_dat_block_rx
  import sd_pkg::*;
#(
  parameter int BLOCK_BYTES = 512,
  parameter int NAC_MAX     = 4096,
  parameter int CNT_W       = 13
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       sd_rx_en_read,
  input  logic       sd_bit_tick,
  input  logic       sd_dat0,
  input  logic       fifo_full,
  output logic [7:0] fifo_data,
  output logic       SD_FIFO_WRITE,
  output logic       read_done,
  output logic       crc_status,
  output logic       timeout,
  output logic       overflow,
  output logic       busy
);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(BLOCK_BYTES * 8 - 1);
  localparam logic [CNT_W-1:0] NAC_LAST  = CNT_W'(NAC_MAX - 1);
  localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(15);
  state_t           state;
  logic             rx_en_d;
  logic [CNT_W-1:0] cnt;
  logic [6:0]       sr;
  logic [15:0]      rx_crc;
  logic [15:0]      crc;
  logic             start;
  logic             crc_en;
  assign start  = (state == IDLE) && sd_rx_en_read && !rx_en_d;
  assign crc_en = sd_bit_tick && (state == RCV_DATA);
  assign busy   = (state != IDLE);
  sd_crc16 #(.POLY(CRC16_POLY)) u_crc (
    .clk  (clk),
    .n_rst(n_rst),
    .clr  (start),
    .en   (crc_en),
    .din  (sd_dat0),
    .crc  (crc)
  );
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      rx_en_d       <= 1'b0;
      cnt           <= '0;
      sr            <= '0;
      rx_crc        <= '0;
      fifo_data     <= '0;
      SD_FIFO_WRITE <= 1'b0;
      read_done     <= 1'b0;
      crc_status    <= 1'b0;
      timeout       <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      rx_en_d       <= sd_rx_en_read;
      SD_FIFO_WRITE <= 1'b0;
      read_done     <= 1'b0;
      // the card cannot be paused mid-block, so a write into a full FIFO is only flagged
      if (SD_FIFO_WRITE && fifo_full) overflow <= 1'b1;
      if (start) begin
        state      <= WAIT_START;
        cnt        <= '0;
        rx_crc     <= '0;
        crc_status <= 1'b0;
        timeout    <= 1'b0;
        overflow   <= 1'b0;
      end else if (sd_bit_tick) begin
        case (state)
          WAIT_START: begin
            if (sd_dat0 == START_BIT) begin
              state <= RCV_DATA;
              cnt   <= '0;
            end else if (cnt == NAC_LAST) begin
              timeout   <= 1'b1;
              read_done <= 1'b1;
              state     <= IDLE;
            end else cnt <= cnt + 1'b1;
          end
          RCV_DATA: begin
            sr  <= {sr[5:0], sd_dat0};
            cnt <= cnt + 1'b1;
            if (cnt[2:0] == 3'd7) begin
              fifo_data     <= {sr, sd_dat0};
              SD_FIFO_WRITE <= 1'b1;
            end
            if (cnt == DATA_LAST) begin
              state <= RCV_CRC;
              cnt   <= '0;
            end
          end
          RCV_CRC: begin
            rx_crc <= {rx_crc[14:0], sd_dat0};
            cnt    <= cnt + 1'b1;
            if (cnt == CRC_LAST) state <= END_BIT;
          end
          END_BIT: begin
            crc_status <= (sd_dat0 == END_BIT_VAL) && (rx_crc == crc);
            read_done  <= 1'b1;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sd_dat_block_rx.sv
// tb_sd_dat_block_rx: randomized block reads against a polynomial-division CRC model,
// with a queue scoreboard checking every FIFO write and every read_done.
module tb_sd_dat_block_rx;
  localparam int NB  = 512;
  localparam int NAC = 4096;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic sd_rx_en_read = 1'b0;
  logic sd_bit_tick = 1'b0;
  logic sd_dat0 = 1'b1;
  logic fifo_full = 1'b0;
  logic [7:0] fifo_data;
  logic SD_FIFO_WRITE, read_done, crc_status, timeout, overflow, busy;
  logic [7:0] blk[NB];
  logic [7:0] exp_q[$];
  logic [2:0] done_q[$];
  int n_chk = 0, n_pass = 0, wr_cnt = 0, done_cnt = 0, gap = 1;

  sd_dat_block_rx dut (
    .clk(clk), .n_rst(n_rst), .sd_rx_en_read(sd_rx_en_read), .sd_bit_tick(sd_bit_tick),
    .sd_dat0(sd_dat0), .fifo_full(fifo_full), .fifo_data(fifo_data),
    .SD_FIFO_WRITE(SD_FIFO_WRITE), .read_done(read_done), .crc_status(crc_status),
    .timeout(timeout), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // CRC as remainder of M(x)*x^16 divided by x^16+x^12+x^5+1
  function automatic logic [15:0] crc_model();
    logic [16:0] rem = '0;
    logic b;
    for (int i = 0; i < NB * 8 + 16; i++) begin
      b = (i < NB * 8) ? blk[i / 8][7 - (i % 8)] : 1'b0;
      rem = {rem[15:0], b};
      if (rem[16]) rem = rem ^ 17'h11021;
    end
    return rem[15:0];
  endfunction

  always @(negedge clk) begin
    if (SD_FIFO_WRITE) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_write: got %0h expected no write", fifo_data);
      end else check("fifo_data", {24'd0, fifo_data}, {24'd0, exp_q.pop_front()});
    end
    if (read_done) begin
      done_cnt++;
      check("done_write_overlap", {31'd0, SD_FIFO_WRITE}, 32'd0);
      if (done_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_done: got read_done expected none");
      end else check("done_status{crc,to,ov}", {29'd0, crc_status, timeout, overflow},
                     {29'd0, done_q.pop_front()});
    end
  end

  task automatic tick(input logic b);
    @(negedge clk);
    sd_dat0 = b;
    sd_bit_tick = 1'b1;
    @(negedge clk);
    sd_bit_tick = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_start();
    @(negedge clk);
    sd_rx_en_read = 1'b1;
    repeat (2) @(negedge clk);
    sd_rx_en_read = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("status_cleared{crc,to,ov}", {29'd0, crc_status, timeout, overflow}, 32'd0);
  endtask

  task automatic send_block(input logic [15:0] crc_flip, input logic endb,
                            input int full_byte, input int retrig_byte, input int abort_byte);
    logic [15:0] c;
    int w0, d0;
    c  = crc_model() ^ crc_flip;
    w0 = wr_cnt;
    d0 = done_cnt;
    do_start();
    repeat ($urandom_range(0, 10)) tick(1'b1);
    tick(1'b0);
    for (int j = 0; j < NB; j++) begin
      if (j == abort_byte) begin
        #2 n_rst = 1'b0;
        #1 check("reset_outputs", {23'd0, fifo_data, SD_FIFO_WRITE, read_done, crc_status,
                                    timeout, overflow, busy}, 32'd0);
        fifo_full = 1'b0;
        repeat (20) @(negedge clk);
        check("no_done_on_reset", done_cnt - d0, 32'd0);
        check("writes_before_reset", wr_cnt - w0, abort_byte);
        n_rst = 1'b1;
        return;
      end
      fifo_full = (j == full_byte);
      if (j == retrig_byte) sd_rx_en_read = 1'b1;
      if (j == retrig_byte + 5) sd_rx_en_read = 1'b0;
      exp_q.push_back(blk[j]);
      for (int k = 7; k >= 0; k--) tick(blk[j][k]);
    end
    fifo_full = 1'b0;
    sd_rx_en_read = 1'b0;
    for (int k = 15; k >= 0; k--) tick(c[k]);
    done_q.push_back({(crc_flip == 16'd0) && endb, 1'b0, full_byte >= 0});
    tick(endb);
    for (int i = 0; i < 50 && done_cnt == d0; i++) @(negedge clk);
    check("read_done_count", done_cnt - d0, 32'd1);
    check("write_count", wr_cnt - w0, NB);
    check("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int w0, d0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {23'd0, fifo_data, SD_FIFO_WRITE, read_done, crc_status,
                            timeout, overflow, busy}, 32'd0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    // all-0xFF block, tick every 4 clks
    gap = 3;
    for (int j = 0; j < NB; j++) blk[j] = 8'hFF;
    check("crc_model_ff", {16'd0, crc_model()}, 32'h7FA1);
    send_block(16'h0000, 1'b1, -1, -1, -1);
    check("crc_status_good", {31'd0, crc_status}, 32'd1);
    gap = 1;
    send_block(16'h0001, 1'b1, -1, -1, -1);
    check("crc_status_bad_crc", {31'd0, crc_status}, 32'd0);
    for (int j = 0; j < NB; j++) blk[j] = 8'($urandom);
    send_block(16'h0000, 1'b0, -1, -1, -1);
    check("crc_status_bad_end", {31'd0, crc_status}, 32'd0);
    for (int j = 0; j < NB; j++) blk[j] = 8'($urandom);
    send_block(16'h0000, 1'b1, -1, -1, -1);
    check("crc_status_random", {31'd0, crc_status}, 32'd1);
    // start-bit timeout
    w0 = wr_cnt;
    d0 = done_cnt;
    do_start();
    done_q.push_back(3'b010);
    for (int i = 0; i < NAC - 1; i++) tick(1'b1);
    check("no_early_timeout", done_cnt - d0, 32'd0);
    check("timeout_low_before", {31'd0, timeout}, 32'd0);
    tick(1'b1);
    check("timeout_done", done_cnt - d0, 32'd1);
    check("timeout_flag", {31'd0, timeout}, 32'd1);
    check("timeout_busy", {31'd0, busy}, 32'd0);
    check("timeout_writes", wr_cnt - w0, 32'd0);
    // counting pattern with FIFO full during byte 100
    for (int j = 0; j < NB; j++) blk[j] = 8'(j);
    send_block(16'h0000, 1'b1, 100, -1, -1);
    check("overflow_set", {31'd0, overflow}, 32'd1);
    check("crc_status_overflow_blk", {31'd0, crc_status}, 32'd1);
    // second start edge mid-block is ignored
    for (int j = 0; j < NB; j++) blk[j] = 8'($urandom);
    send_block(16'h0000, 1'b1, -1, 50, -1);
    check("overflow_cleared", {31'd0, overflow}, 32'd0);
    // reset mid-block
    for (int j = 0; j < NB; j++) blk[j] = 8'(j);
    send_block(16'h0000, 1'b1, 100, -1, 300);
    check("exp_queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
